// File: rtl/snd_cmd_mailbox.sv
// 68k<->6502 sound-command mailbox: command FIFO toward the sound CPU with an NMI
// sequencer, and a one-byte reply latch back to the 68k. Optional macro: SNDCMD_FIFO_EN.
`timescale 1ns/1ps
`default_nettype none

module snd_cmd_mailbox #(
  parameter int DEPTH   = 4,
  parameter int NMI_GAP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               ibd_wdata,
  input  logic                     sndwr_b,
  input  logic                     sndrd_b,
  output logic [7:0]               ibd_rdata,
  output logic                     ibd_rd_en,
  output logic                     sndint_b,
  input  logic [7:0]               sd_wdata,
  input  logic                     wr68k_b,
  input  logic                     rd68k_b,
  output logic [7:0]               sd_rdata,
  output logic                     sd_rd_en,
  output logic                     sndnmi_b,
  output logic [$clog2(DEPTH):0]   m2s_count,
  output logic                     m2s_ovr,
  output logic                     s2m_ovr
);

`ifdef SNDCMD_FIFO_EN
  localparam int EFF_DEPTH = DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = (EFF_DEPTH > 1) ? $clog2(EFF_DEPTH) : 1;
  localparam int MEM_N = 1 << PTR_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(EFF_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(EFF_DEPTH);
  localparam int GAP_W = (NMI_GAP > 1) ? $clog2(NMI_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(NMI_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} nmi_state_t;

  // Strobe sync and edge-history flops; data buses are captured alongside.
  logic       sndwr_s, sndwr_p, sndrd_s, sndrd_p;
  logic       wr68k_s, wr68k_p, rd68k_s, rd68k_p;
  logic [7:0] ibd_q, sd_q;

  // NOTE: every sequential block uses non-blocking (<=) so all flops sample
  // pre-edge values; blocking here would chain the sync and history flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sndwr_s <= 1'b1;
      sndwr_p <= 1'b1;
      sndrd_s <= 1'b1;
      sndrd_p <= 1'b1;
      wr68k_s <= 1'b1;
      wr68k_p <= 1'b1;
      rd68k_s <= 1'b1;
      rd68k_p <= 1'b1;
      ibd_q   <= 8'h00;
      sd_q    <= 8'h00;
    end else begin
      sndwr_s <= sndwr_b;
      sndwr_p <= sndwr_s;
      sndrd_s <= sndrd_b;
      sndrd_p <= sndrd_s;
      wr68k_s <= wr68k_b;
      wr68k_p <= wr68k_s;
      rd68k_s <= rd68k_b;
      rd68k_p <= rd68k_s;
      ibd_q   <= ibd_wdata;
      sd_q    <= sd_wdata;
    end
  end

  logic m68k_wr_fall, m68k_rd_rise, s6502_wr_fall, s6502_rd_rise;
  assign m68k_wr_fall  = sndwr_p & ~sndwr_s;
  assign m68k_rd_rise  = ~sndrd_p & sndrd_s;
  assign s6502_wr_fall = wr68k_p & ~wr68k_s;
  assign s6502_rd_rise = ~rd68k_p & rd68k_s;

  assign sd_rd_en  = ~rd68k_s;
  assign ibd_rd_en = ~sndrd_s;

  // ---------------- 68k -> 6502 command queue ----------------
  logic [7:0]       mem [MEM_N];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop, push, full, lost, overwrite;

  assign full = (m2s_count == FULL_CNT);
  assign pop  = s6502_rd_rise && (m2s_count != '0);
  // Pop is applied first, so a full queue still accepts a push in a pop cycle.
  assign push = m68k_wr_fall && (!full || pop);
  assign lost = m68k_wr_fall && full && !pop;
`ifdef SNDCMD_FIFO_EN
  assign overwrite = 1'b0;
`else
  assign overwrite = lost;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push || overwrite)
      mem[wr_ptr] <= ibd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      m2s_count <= '0;
      m2s_ovr   <= 1'b0;
      sd_rdata  <= 8'h00;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (lost) m2s_ovr <= 1'b1;
      m2s_count <= m2s_count + CNT_W'(push) - CNT_W'(pop);
      // Head is re-registered each cycle; an empty queue keeps the last byte.
      if (m2s_count != '0)
        sd_rdata <= mem[rd_ptr];
    end
  end

  // ---------------- NMI sequencer ----------------
  nmi_state_t       nmi_state, nmi_state_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_state <= S_IDLE;
      gap_cnt   <= '0;
    end else begin
      nmi_state <= nmi_state_n;
      gap_cnt   <= gap_cnt_n;
    end
  end

  // NOTE: all outputs of this block get a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    nmi_state_n = nmi_state;
    gap_cnt_n   = gap_cnt;
    sndnmi_b    = 1'b1;
    unique case (nmi_state)
      S_IDLE: begin
        if (m2s_count != '0) nmi_state_n = S_ASSERT;
      end
      S_ASSERT: begin
        sndnmi_b = 1'b0;
        if (pop) begin
          nmi_state_n = S_GAP;
          gap_cnt_n   = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST)
          nmi_state_n = (m2s_count != '0) ? S_ASSERT : S_IDLE;
        else
          gap_cnt_n = gap_cnt + 1'b1;
      end
      default: nmi_state_n = S_IDLE;
    endcase
  end

  // ---------------- 6502 -> 68k reply latch ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ibd_rdata <= 8'h00;
      sndint_b  <= 1'b1;
      s2m_ovr   <= 1'b0;
    end else if (s6502_wr_fall) begin
      // A new reply beats a simultaneous 68k read acknowledge.
      ibd_rdata <= sd_q;
      sndint_b  <= 1'b0;
      if (!sndint_b) s2m_ovr <= 1'b1;
    end else if (m68k_rd_rise) begin
      sndint_b <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_snd_cmd_mailbox.sv
// Scoreboard bench for snd_cmd_mailbox: read strobes are matched against queued
// expected bytes by a monitor; status outputs are checked inline by the stimulus.
`timescale 1ns/1ps

module tb_snd_cmd_mailbox;

`ifdef SNDCMD_FIFO_EN
  localparam int EXP_DEPTH = 4;
`else
  localparam int EXP_DEPTH = 1;
`endif
  localparam int NMI_GAP = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ibd_wdata, sd_wdata;
  logic       sndwr_b, sndrd_b, wr68k_b, rd68k_b;
  logic [7:0] ibd_rdata, sd_rdata;
  logic       ibd_rd_en, sd_rd_en, sndint_b, sndnmi_b;
  logic [2:0] m2s_count;
  logic       m2s_ovr, s2m_ovr;

  snd_cmd_mailbox #(.DEPTH(4), .NMI_GAP(NMI_GAP)) dut (
    .clk(clk), .reset(reset),
    .ibd_wdata(ibd_wdata), .sndwr_b(sndwr_b), .sndrd_b(sndrd_b),
    .ibd_rdata(ibd_rdata), .ibd_rd_en(ibd_rd_en), .sndint_b(sndint_b),
    .sd_wdata(sd_wdata), .wr68k_b(wr68k_b), .rd68k_b(rd68k_b),
    .sd_rdata(sd_rdata), .sd_rd_en(sd_rd_en), .sndnmi_b(sndnmi_b),
    .m2s_count(m2s_count), .m2s_ovr(m2s_ovr), .s2m_ovr(s2m_ovr)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         nmi_falls = 0;
  logic [7:0] exp_sd[$];
  logic [7:0] exp_ibd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Monitor: on each read-enable rising edge compare the presented byte.
  initial begin
    logic sd_prev, ibd_prev, nmi_prev;
    sd_prev = 1'b0; ibd_prev = 1'b0; nmi_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (sd_rd_en && !sd_prev) begin
        if (exp_sd.size() == 0) begin
          n_checks++;
          $display("FAIL sd_unexpected: got sd_rd_en with 0x%0h, want no read", sd_rdata);
        end else check("sd_rdata", sd_rdata, exp_sd.pop_front());
      end
      if (ibd_rd_en && !ibd_prev) begin
        if (exp_ibd.size() == 0) begin
          n_checks++;
          $display("FAIL ibd_unexpected: got ibd_rd_en with 0x%0h, want no read", ibd_rdata);
        end else check("ibd_rdata", ibd_rdata, exp_ibd.pop_front());
      end
      if (nmi_prev && !sndnmi_b) nmi_falls++;
      sd_prev  = sd_rd_en;
      ibd_prev = ibd_rd_en;
      nmi_prev = sndnmi_b;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // All tasks start and end on a falling clock edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic m68k_write(input logic [7:0] d);
    ibd_wdata = d; sndwr_b = 1'b0;
    tick(2);
    sndwr_b = 1'b1;
    tick(3);
  endtask

  task automatic s6502_read(input logic [7:0] exp);
    exp_sd.push_back(exp);
    rd68k_b = 1'b0;
    tick(2);
    rd68k_b = 1'b1;
    tick(1);
  endtask

  task automatic s6502_write(input logic [7:0] d);
    sd_wdata = d; wr68k_b = 1'b0;
    tick(2);
    wr68k_b = 1'b1;
    tick(3);
  endtask

  task automatic m68k_read(input logic [7:0] exp);
    exp_ibd.push_back(exp);
    sndrd_b = 1'b0;
    tick(2);
    sndrd_b = 1'b1;
    tick(3);
  endtask

  // Length of the next sndnmi_b high period, bounded on both sides.
  task automatic measure_gap(output int hi);
    int waited;
    waited = 0;
    while (!sndnmi_b && waited < 10) begin @(negedge clk); waited++; end
    hi = 0;
    while (sndnmi_b && hi < 20) begin @(negedge clk); hi++; end
  endtask

  initial begin
    int f0, hi;
    reset = 1'b1; sndwr_b = 1'b1; sndrd_b = 1'b1; wr68k_b = 1'b1; rd68k_b = 1'b1;
    ibd_wdata = 8'h00; sd_wdata = 8'h00;
    tick(4);
    reset = 1'b0;
    tick(2);

    check("rst_count", m2s_count, 0);
    check("rst_nmi", sndnmi_b, 1);
    check("rst_int", sndint_b, 1);
    check("rst_m2s_ovr", m2s_ovr, 0);
    check("rst_s2m_ovr", s2m_ovr, 0);
    check("rst_sd_rd_en", sd_rd_en, 0);
    check("rst_ibd_rd_en", ibd_rd_en, 0);
    check("rst_sd_rdata", sd_rdata, 8'h00);
    check("rst_ibd_rdata", ibd_rdata, 8'h00);

    // Reset asserted while a 68k write strobe is low: the write is discarded.
    ibd_wdata = 8'hEE; sndwr_b = 1'b0; reset = 1'b1;
    tick(3);
    sndwr_b = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    check("midrst_count", m2s_count, 0);
    check("midrst_nmi", sndnmi_b, 1);
    check("midrst_ovr", m2s_ovr, 0);
    check("midrst_sd_rdata", sd_rdata, 8'h00);

    // Single command round trip.
    m68k_write(8'h5A);
    check("single_nmi_low", sndnmi_b, 0);
    check("single_count", m2s_count, 1);
    s6502_read(8'h5A);
    tick(4);
    check("single_count_after", m2s_count, 0);
    check("single_nmi_after", sndnmi_b, 1);

`ifdef SNDCMD_FIFO_EN
    // Burst into a 4-deep queue with one overflow.
    do_reset();
    f0 = nmi_falls;
    for (int i = 1; i <= 5; i++) m68k_write(8'(i));
    check("burst_count", m2s_count, 4);
    check("burst_ovr", m2s_ovr, 1);
    for (int i = 1; i <= 4; i++) begin
      check("burst_nmi_before_read", sndnmi_b, 0);
      s6502_read(8'(i));
      if (i < 4) begin
        measure_gap(hi);
        check("burst_nmi_gap", hi, NMI_GAP);
      end else tick(4);
    end
    check("burst_count_after", m2s_count, 0);
    check("burst_nmi_after", sndnmi_b, 1);
    check("burst_nmi_falls", nmi_falls - f0, 4);
`else
    // Single latch: second write overwrites without a new NMI edge.
    do_reset();
    f0 = nmi_falls;
    m68k_write(8'h11);
    check("latch_ovr_first", m2s_ovr, 0);
    m68k_write(8'h22);
    check("latch_ovr", m2s_ovr, 1);
    check("latch_count", m2s_count, 1);
    check("latch_nmi_low", sndnmi_b, 0);
    check("latch_nmi_falls", nmi_falls - f0, 1);
    s6502_read(8'h22);
    tick(4);
    check("latch_count_after", m2s_count, 0);
    check("latch_nmi_after", sndnmi_b, 1);
`endif

    // Reply path with overwrite.
    do_reset();
    s6502_write(8'hC3);
    check("reply_int", sndint_b, 0);
    check("reply_data", ibd_rdata, 8'hC3);
    check("reply_ovr_first", s2m_ovr, 0);
    s6502_write(8'h3C);
    check("reply_ovr", s2m_ovr, 1);
    m68k_read(8'h3C);
    check("reply_int_after", sndint_b, 1);
    check("reply_data_kept", ibd_rdata, 8'h3C);

    // Full queue: push and pop land in the same cycle.
    do_reset();
    for (int i = 0; i < EXP_DEPTH; i++) m68k_write(8'hA0 + 8'(i));
    check("coll_full", m2s_count, 3'(EXP_DEPTH));
    exp_sd.push_back(8'hA0);
    rd68k_b = 1'b0;
    tick(2);
    rd68k_b = 1'b1; ibd_wdata = 8'hB0; sndwr_b = 1'b0;
    tick(2);
    sndwr_b = 1'b1;
    tick(3);
    check("coll_count", m2s_count, 3'(EXP_DEPTH));
    check("coll_ovr", m2s_ovr, 0);
    for (int i = 1; i < EXP_DEPTH; i++) begin
      s6502_read(8'hA0 + 8'(i));
      tick(3);
    end
    s6502_read(8'hB0);
    tick(4);
    check("coll_drained", m2s_count, 0);

    // Reply write and 68k read acknowledge in the same cycle.
    do_reset();
    s6502_write(8'hC3);
    exp_ibd.push_back(8'hC3);
    sndrd_b = 1'b0;
    tick(2);
    sndrd_b = 1'b1; sd_wdata = 8'h77; wr68k_b = 1'b0;
    tick(2);
    wr68k_b = 1'b1;
    tick(3);
    check("rcoll_int", sndint_b, 0);
    check("rcoll_data", ibd_rdata, 8'h77);

    tick(4);
    check("sd_queue_empty", exp_sd.size(), 0);
    check("ibd_queue_empty", exp_ibd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
